score_tracker: RTL and testbench



---
 rtl/score_pkg.sv | 12 +
 rtl/bcd_incr.sv | 20 ++
 rtl/score_tracker.sv | 85 ++++++++
 tb/tb_score_tracker.sv | 132 +++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared types, widths and BCD compare for the score/game-state logic
package score_pkg;
  localparam int LIVES_W   = 3;
  localparam int BCD_MAX_W = 64;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} tracker_state_t;
  // Valid BCD orders like unsigned binary, so MSD-first digit compare is a plain
  // unsigned compare of the zero-extended packed vectors.
  function automatic logic bcd_gt(input logic [BCD_MAX_W-1:0] a, input logic [BCD_MAX_W-1:0] b);
    return a > b;
  endfunction
endpackage

// File: rtl/bcd_incr.sv
// bcd_incr: combinational BCD +1 over DIGITS digits, wrapping all-nines to zero
//   d_i : packed BCD operand
//   q_o : d_i + 1, modulo 10^DIGITS
module bcd_incr
  import score_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  bcd_digit_t [DIGITS-1:0] d_i,
  output bcd_digit_t [DIGITS-1:0] q_o
);
  logic c;
  always_comb begin
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      q_o[i] = c ? ((d_i[i] == 4'd9) ? 4'd0 : d_i[i] + 4'd1) : d_i[i];
      c = c && (d_i[i] == 4'd9);
    end
  end
endmodule

// File: rtl/score_tracker.sv
// score_tracker: lives, extra-life awards, game-over detection and high-score retention
//   clk_i, reset_i (async, active-high)  score_i: BCD score  game_start_i / ship_lost_i: 1-cycle events
//   lives_o, high_score_o, game_over_o, bonus_pulse_o, new_high_o: registered HUD/sound outputs
//   HIGH_SCORE_LIVE_EN: high score tracks the score live during play, new_high becomes sticky
module score_tracker
  import score_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BONUS_DIGIT = 3,
  parameter int START_LIVES = 3,
  parameter int MAX_LIVES   = 7
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [4*DIGITS-1:0] score_i,
  input  logic                game_start_i,
  input  logic                ship_lost_i,
  output logic [LIVES_W-1:0]  lives_o,
  output logic [4*DIGITS-1:0] high_score_o,
  output logic                game_over_o,
  output logic                bonus_pulse_o,
  output logic                new_high_o
);
  localparam int PW = DIGITS - BONUS_DIGIT;
  tracker_state_t state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [4*DIGITS-1:0] high_q, high_d;
  logic [4*PW-1:0] mark_q, mark_d, mark_inc, prefix;
  logic bonus_q, new_high_q, new_high_d, award, play, gt;
  assign prefix = score_i[4*DIGITS-1:4*BONUS_DIGIT];
  assign play   = state_q == PLAY;
  // The mark chases the score prefix one step per cycle, so jumps and wraps drain as a pulse train.
  assign award  = play && (mark_q != prefix);
  assign gt     = bcd_gt(BCD_MAX_W'(score_i), BCD_MAX_W'(high_q));
  bcd_incr #(.DIGITS(PW)) u_mark_incr (.d_i(mark_q), .q_o(mark_inc));
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    high_d  = high_q;
    mark_d  = mark_q;
    if (!play) begin
      mark_d = prefix;
      if (game_start_i) begin
        state_d = PLAY;
        lives_d = LIVES_W'(START_LIVES);
      end
    end else if (award) begin
      mark_d = mark_inc;
      if (!ship_lost_i && lives_q < LIVES_W'(MAX_LIVES)) lives_d = lives_q + 1'b1;
    end else if (ship_lost_i) begin
      lives_d = lives_q - 1'b1;
      if (lives_q == LIVES_W'(1)) begin
        state_d = OVER;
        high_d  = gt ? score_i : high_q;
      end
    end
`ifdef HIGH_SCORE_LIVE_EN
    if (play && gt) high_d = score_i;
    new_high_d = (state_d == PLAY) && (new_high_q || (play && gt));
`else
    new_high_d = (state_d == PLAY) && gt;
`endif
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q    <= IDLE;
      lives_q    <= '0;
      high_q     <= '0;
      mark_q     <= '0;
      bonus_q    <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      high_q     <= high_d;
      mark_q     <= mark_d;
      bonus_q    <= award;
      new_high_q <= new_high_d;
    end
  assign lives_o       = lives_q;
  assign high_score_o  = high_q;
  assign game_over_o   = state_q != PLAY;
  assign bonus_pulse_o = bonus_q;
  assign new_high_o    = new_high_q;
endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed and random game sequences checked against an integer-level game model
module tb_score_tracker;
  localparam int DIGITS = 4, BONUS_DIGIT = 3, START_LIVES = 3, MAX_LIVES = 7;
  localparam int P10B = 1000;
  localparam int MODP = 10;
  logic clk = 1'b0;
  logic reset_i, game_start_i, ship_lost_i;
  logic [4*DIGITS-1:0] score_i;
  logic [2:0] lives_o;
  logic [4*DIGITS-1:0] high_score_o;
  logic game_over_o, bonus_pulse_o, new_high_o;
  int n_chk = 0, n_fail = 0;
  bit m_play, m_bonus, m_nh;
  int m_lives, m_high, m_mark;
  always #5 clk = ~clk;
  score_tracker #(.DIGITS(DIGITS), .BONUS_DIGIT(BONUS_DIGIT), .START_LIVES(START_LIVES), .MAX_LIVES(MAX_LIVES)) dut (
    .clk_i(clk), .reset_i(reset_i), .score_i(score_i), .game_start_i(game_start_i), .ship_lost_i(ship_lost_i),
    .lives_o(lives_o), .high_score_o(high_score_o), .game_over_o(game_over_o),
    .bonus_pulse_o(bonus_pulse_o), .new_high_o(new_high_o));
  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    int d;
    d = 1;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".lives"}, 32'(lives_o), 32'(m_lives));
    chk({tag, ".high"}, 32'(high_score_o), 32'(to_bcd(m_high)));
    chk({tag, ".over"}, 32'(game_over_o), 32'(!m_play));
    chk({tag, ".bonus"}, 32'(bonus_pulse_o), 32'(m_bonus));
    chk({tag, ".new_high"}, 32'(new_high_o), 32'(m_nh));
  endtask
  task automatic model_reset();
    m_play = 0; m_bonus = 0; m_nh = 0; m_lives = 0; m_high = 0; m_mark = 0;
  endtask
  task automatic step(input string tag, input bit st, input bit sl, input int sc);
    int pre;
    bit was_play, aw, gt;
    game_start_i = st; ship_lost_i = sl; score_i = to_bcd(sc);
    pre = (sc / P10B) % MODP;
    was_play = m_play;
    gt = sc > m_high;
    aw = was_play && (m_mark != pre);
    m_bonus = aw;
    if (!was_play) begin
      m_mark = pre;
      if (st) begin m_play = 1; m_lives = START_LIVES; end
    end else if (aw) begin
      m_mark = (m_mark + 1) % MODP;
      if (!sl && m_lives < MAX_LIVES) m_lives++;
    end else if (sl) begin
      if (m_lives == 1) begin
        m_lives = 0; m_play = 0;
        if (gt) m_high = sc;
      end else m_lives--;
    end
`ifdef HIGH_SCORE_LIVE_EN
    if (was_play && gt) m_high = sc;
    m_nh = m_play && (m_nh || (was_play && gt));
`else
    m_nh = m_play && gt;
`endif
    @(posedge clk); #1;
    chk_all(tag);
  endtask
  initial begin
    int sc;
    bit st, sl;
    reset_i = 1; game_start_i = 0; ship_lost_i = 0; score_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_all("reset");
    @(negedge clk) reset_i = 0;
    // game 1: start, three losses at 0450
    step("start1", 1, 0, 0);
    for (int i = 0; i < 3; i++) step("lose1", 0, 1, 450);
    step("idle_lost", 0, 1, 450);
    // game 2: stays below the high score
    step("start2", 1, 0, 0);
    step("play2", 0, 0, 300);
    step("ign_start", 1, 0, 300);
    for (int i = 0; i < 3; i++) step("lose2", 0, 1, 300);
    // game 3: single crossing, multi-step jump, saturation, award+loss collision
    step("start3", 1, 0, 0);
    step("pre990", 0, 0, 990);
    step("cross1010", 0, 0, 1010);
    step("hold1010", 0, 0, 1010);
    step("lose3", 0, 1, 1010);
    step("s500", 0, 0, 500);
    for (int i = 0; i < 12; i++) step("drain", 0, 0, 500);
    step("lose3b", 0, 1, 500);
    step("lose3c", 0, 1, 500);
    step("jump3200", 0, 0, 3200);
    for (int i = 0; i < 3; i++) step("jumpdrain", 0, 0, 3200);
    step("sat4000", 0, 0, 4000);
    step("sat5000", 0, 0, 5000);
    step("sat6000", 0, 0, 6000);
    for (int i = 0; i < 6; i++) step("down", 0, 1, 6000);
    step("collide", 0, 1, 7000);
    step("last", 0, 1, 7000);
    // mid-game asynchronous reset
    step("start4", 1, 0, 100);
    step("play4", 0, 0, 9990);
    reset_i = 1; #1;
    model_reset();
    chk_all("async_rst");
    #3 reset_i = 0;
    step("after_rst", 0, 0, 9990);
    step("start5", 1, 0, 9990);
    step("wrap", 0, 0, 20);
    step("wrap_hold", 0, 0, 20);
    // random games
    sc = 0;
    for (int i = 0; i < 600; i++) begin
      sc = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 9999)) : (sc + int'($urandom_range(0, 150))) % 10000;
      st = $urandom_range(0, 15) == 0;
      sl = $urandom_range(0, 7) == 0;
      step("rand", st, sl, sc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
